// File: rtl/dshot_multi_motor_control.sv
// Multi-channel DShot transmitter. One shared bit timer drives NUM_MOTORS
// lanes, so every line starts its frame on the same clock. Each lane holds
// its own shadow command, builds its packet with CRC at frame start and
// shifts it out MSB first. The shared core also handles periodic
// retransmission, the arming gate and the link-loss failsafe.

// Per-channel lane: shadow registers, packet shift register, output flop.
module dshot_lane #(
    parameter int SW  = 5,
    parameter int T1H = 19,
    parameter int T0H = 9
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [10:0]   cmd_in,
    input  logic          tlm_in,
    input  logic          frame_start,
    input  logic          adv,
    input  logic          send_nxt,
    input  logic          zero,
    input  logic [SW-1:0] smp_nxt,
    output logic          tx_out
);
    localparam logic [SW-1:0] T1 = SW'(T1H);
    localparam logic [SW-1:0] T0 = SW'(T0H);

    logic [10:0] cmd_q, cmd_d;
    logic        tlm_q, tlm_d;
    logic [15:0] shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic [11:0] v;
    logic [3:0]  crc;
    logic        bit_nxt;

    // Packet build, shift and next line level for the sample about to be presented.
    always_comb begin
        cmd_d   = load ? cmd_in : cmd_q;
        tlm_d   = load ? tlm_in : tlm_q;
        v       = zero ? 12'd0 : {cmd_q, tlm_q};
        crc     = v[3:0] ^ v[7:4] ^ v[11:8];
        shreg_d = shreg_q;
        if (frame_start) begin
            shreg_d = {v, crc};
        end else if (adv) begin
            shreg_d = {shreg_q[14:0], 1'b0};
        end
        bit_nxt = shreg_d[15];
        tx_d    = send_nxt && (smp_nxt < (bit_nxt ? T1 : T0));
    end

    // Lane state flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            tlm_q   <= 1'b0;
            shreg_q <= '0;
            tx_q    <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            tlm_q   <= tlm_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_out = tx_q;
endmodule

module dshot_multi_motor_control #(
    parameter int NUM_MOTORS        = 4,
    parameter int BASE_FREQ         = 16000000,
    parameter int DSHOT_FREQ        = 600000,
    parameter int GAP_BITS          = 4,
    parameter int FRAME_PERIOD_CLKS = 16000,
    parameter int TIMEOUT_FRAMES    = 50
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [11*NUM_MOTORS-1:0] commands,
    input  logic [NUM_MOTORS-1:0]   telemetry_req,
    input  logic                    load,
    input  logic                    armed,
    output logic [NUM_MOTORS-1:0]   tx_out,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    failsafe
);
    localparam int CLKS_PER_BIT = BASE_FREQ / DSHOT_FREQ;
    localparam int T1H          = CLKS_PER_BIT * 3 / 4;
    localparam int T0H          = CLKS_PER_BIT * 3 / 8;
    localparam int GAP_CLKS     = GAP_BITS * CLKS_PER_BIT;
    localparam int SW           = $clog2(CLKS_PER_BIT + 1);
    localparam int GW           = $clog2(GAP_CLKS + 1);
    localparam int PW           = $clog2(FRAME_PERIOD_CLKS + 1);
    localparam int TW           = $clog2(TIMEOUT_FRAMES + 2);

    localparam logic [SW-1:0] SMP_LAST    = SW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CLKS - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(FRAME_PERIOD_CLKS - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_FRAMES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pending_q, pending_d;
    logic          failsafe_q, failsafe_d;
    logic          frame_start, adv, send_nxt, start_cond, zero;

    // Shared frame sequencer, period timer, pending flag and timeout counter.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        smp_d       = smp_q;
        gap_d       = gap_q;
        frame_start = 1'b0;
        adv         = 1'b0;
        start_cond  = pending_q || (period_q == PERIOD_LAST);
        case (state_q)
            ST_IDLE: begin
                if (start_cond) begin
                    frame_start = 1'b1;
                    state_d     = ST_SEND;
                    bit_d       = '0;
                    smp_d       = '0;
                end
            end
            ST_SEND: begin
                if (smp_q == SMP_LAST) begin
                    smp_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        adv   = 1'b1;
                    end
                end else begin
                    smp_d = smp_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    // Back-to-back frames skip IDLE entirely.
                    if (start_cond) begin
                        frame_start = 1'b1;
                        state_d     = ST_SEND;
                        bit_d       = '0;
                        smp_d       = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        send_nxt = (state_d == ST_SEND);
        // A load coinciding with a frame start still leaves pending set.
        pending_d  = load ? 1'b1 : (frame_start ? 1'b0 : pending_q);
        period_d   = frame_start ? '0 :
                     ((period_q == PERIOD_LAST) ? period_q : period_q + 1'b1);
        tmo_d      = load ? '0 :
                     ((frame_start && (tmo_q != TMO_MAX)) ? tmo_q + 1'b1 : tmo_q);
        failsafe_d = (TIMEOUT_FRAMES != 0) && (tmo_d == TMO_MAX);
        zero       = !armed || failsafe_q;
    end

    // Shared control flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            smp_q      <= '0;
            gap_q      <= '0;
            period_q   <= '0;
            tmo_q      <= '0;
            pending_q  <= 1'b0;
            failsafe_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            smp_q      <= smp_d;
            gap_q      <= gap_d;
            period_q   <= period_d;
            tmo_q      <= tmo_d;
            pending_q  <= pending_d;
            failsafe_q <= failsafe_d;
        end
    end

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_lane
        dshot_lane #(.SW(SW), .T1H(T1H), .T0H(T0H)) u_lane (
            .clock       (clock),
            .reset_n     (reset_n),
            .load        (load),
            .cmd_in      (commands[11*i +: 11]),
            .tlm_in      (telemetry_req[i]),
            .frame_start (frame_start),
            .adv         (adv),
            .send_nxt    (send_nxt),
            .zero        (zero),
            .smp_nxt     (smp_d),
            .tx_out      (tx_out[i])
        );
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_GAP) && (gap_q == GAP_LAST);
    assign failsafe   = failsafe_q;
endmodule

// File: tb/tb_dshot_multi_motor_control.sv
// Bench for dshot_multi_motor_control: stimulus pushes expected frames into a
// scoreboard; a monitor decodes every frame from the lines and compares.
module tb_dshot_multi_motor_control;
    localparam int NM        = 4;
    localparam int CPB       = 16000000 / 600000;
    localparam int T1H       = CPB * 3 / 4;
    localparam int T0H       = CPB * 3 / 8;
    localparam int GAPC      = 4 * CPB;
    localparam int FRAME_LEN = 16 * CPB + GAPC;
    localparam int PER       = 1000;
    localparam int TMO       = 4;

    logic                clock = 1'b0;
    logic                reset_n = 1'b1;
    logic [11*NM-1:0]    commands = '0;
    logic [NM-1:0]       telemetry_req = '0;
    logic                load = 1'b0;
    logic                armed = 1'b1;
    logic [NM-1:0]       tx_out;
    logic                busy, frame_done, failsafe;

    dshot_multi_motor_control #(
        .NUM_MOTORS(NM), .FRAME_PERIOD_CLKS(PER), .TIMEOUT_FRAMES(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .commands(commands),
        .telemetry_req(telemetry_req), .load(load), .armed(armed),
        .tx_out(tx_out), .busy(busy), .frame_done(frame_done), .failsafe(failsafe)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [NM-1:0][15:0] pkt;
        int                  start;
    } exp_t;

    exp_t sb_q[$];
    int n_chk = 0, n_fail = 0, pushed = 0, frames_seen = 0, frames_aborted = 0;
    int m_cmd[NM];
    int m_tlm[NM];

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Packet from the DShot rules: value = cmd*2+tlm, crc = xor of nibbles.
    function automatic logic [15:0] ref_pkt(input int cmd, input int tlm);
        int v, crc;
        v   = (cmd % 2048) * 2 + (tlm % 2);
        crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
        return 16'(v * 16 + crc);
    endfunction

    task automatic push_frame(input int st, input bit zero);
        exp_t e;
        for (int i = 0; i < NM; i++)
            e.pkt[i] = zero ? ref_pkt(0, 0) : ref_pkt(m_cmd[i], m_tlm[i]);
        e.start = st;
        sb_q.push_back(e);
        pushed++;
    endtask

    task automatic push_lit(input logic [NM-1:0][15:0] p, input int st);
        exp_t e;
        e.pkt   = p;
        e.start = st;
        sb_q.push_back(e);
        pushed++;
    endtask

    // Called on a negedge; load is sampled by the next posedge.
    task automatic do_load(output int l);
        for (int i = 0; i < NM; i++) begin
            commands[11*i +: 11] = 11'(m_cmd[i]);
            telemetry_req[i]     = 1'(m_tlm[i]);
        end
        load = 1'b1;
        l    = cyc;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic randomize_cmds();
        for (int i = 0; i < NM; i++) begin
            m_cmd[i] = int'($urandom_range(0, 2047));
            m_tlm[i] = int'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((frames_seen + frames_aborted) < pushed && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("frames_consumed", frames_seen + frames_aborted, pushed);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Monitor: decode each frame and compare against the scoreboard head.
    int                  m_st, m_fdcnt, m_fdcyc;
    bit                  m_have, m_abort, m_badbusy, m_badgap;
    exp_t                m_e;
    int                  m_lead[NM];
    bit                  m_low[NM];
    bit                  m_badw[NM];
    logic [NM-1:0][15:0] m_got;

    initial begin : mon
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && tx_out != '0) begin
                m_st   = cyc;
                m_have = (sb_q.size() > 0);
                chk("frame_expected", longint'(m_have), 1);
                if (m_have) m_e = sb_q.pop_front();
                chk("lines_aligned", tx_out, {NM{1'b1}});
                if (m_have && m_e.start >= 0) chk("start_cycle", m_st, m_e.start);
                m_abort = 0; m_badbusy = 0; m_badgap = 0; m_fdcnt = 0; m_fdcyc = 0;
                m_got = '0;
                for (int c = 0; c < NM; c++) m_badw[c] = 0;
                for (int b = 0; b < 16; b++) begin
                    for (int c = 0; c < NM; c++) begin m_lead[c] = 0; m_low[c] = 0; end
                    for (int s = 0; s < CPB; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clock);
                        if (reset_n !== 1'b1) m_abort = 1;
                        if (m_abort) break;
                        if (busy !== 1'b1) m_badbusy = 1;
                        for (int c = 0; c < NM; c++) begin
                            if (tx_out[c] === 1'b1) begin
                                if (m_low[c]) m_badw[c] = 1;
                                else m_lead[c]++;
                            end else begin
                                m_low[c] = 1;
                            end
                        end
                    end
                    if (m_abort) break;
                    for (int c = 0; c < NM; c++) begin
                        if (m_lead[c] == T1H) m_got[c][15-b] = 1'b1;
                        else if (m_lead[c] != T0H) m_badw[c] = 1;
                    end
                end
                if (!m_abort) begin
                    for (int g = 0; g < GAPC; g++) begin
                        @(negedge clock);
                        if (reset_n !== 1'b1) begin m_abort = 1; break; end
                        if (tx_out !== '0) m_badgap = 1;
                        if (busy !== 1'b1) m_badbusy = 1;
                        if (frame_done === 1'b1) begin m_fdcnt++; m_fdcyc = cyc; end
                    end
                end
                if (!m_abort) begin
                    for (int c = 0; c < NM; c++) begin
                        chk($sformatf("pulse_widths_ch%0d", c), longint'(m_badw[c]), 0);
                        if (m_have) chk($sformatf("packet_ch%0d", c), m_got[c], m_e.pkt[c]);
                    end
                    chk("busy_in_frame", longint'(m_badbusy), 0);
                    chk("gap_low", longint'(m_badgap), 0);
                    chk("frame_done_count", m_fdcnt, 1);
                    chk("frame_done_offset", m_fdcyc - m_st, FRAME_LEN - 1);
                    if (m_have) frames_seen++;
                end else if (m_have) begin
                    frames_aborted++;
                end
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int L, S, R, hits;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_tx_out", tx_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_failsafe", failsafe, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single channel, known packet and load-to-line latency.
        m_cmd = '{1046, 0, 0, 0};
        m_tlm = '{0, 0, 0, 0};
        do_load(L);
        push_lit({16'h0000, 16'h0000, 16'h0000, 16'h82C6}, L + 2);
        wait_done(2 * FRAME_LEN);
        repeat (2) @(negedge clock);

        // Distinct commands on every channel, telemetry on channel 3.
        m_cmd = '{0, 48, 1046, 2047};
        m_tlm = '{0, 0, 0, 1};
        do_load(L);
        push_frame(L + 2, 0);
        wait_done(2 * FRAME_LEN);

        // Random loads from idle.
        repeat (4) begin
            repeat (2) @(negedge clock);
            randomize_cmds();
            do_load(L);
            push_frame(L + 2, 0);
            wait_done(2 * FRAME_LEN);
        end

        // Two loads during a frame: in-flight frame unchanged, last load wins.
        repeat (2) @(negedge clock);
        randomize_cmds();
        do_load(L);
        S = L + 2;
        push_frame(S, 0);
        wait_until(S + 100);
        randomize_cmds();
        do_load(L);
        wait_until(S + 300);
        randomize_cmds();
        do_load(L);
        S = S + FRAME_LEN;
        push_frame(S, 0);
        wait_done(3 * FRAME_LEN);

        // Periodic retransmission, then failsafe after TMO frame starts.
        for (int k = 1; k < TMO; k++) push_frame(S + k * PER, 0);
        push_frame(S + TMO * PER, 1);
        wait_until(S + (TMO - 2) * PER + FRAME_LEN);
        chk("failsafe_before_timeout", failsafe, 0);
        wait_until(S + (TMO - 1) * PER + 2);
        chk("failsafe_set", failsafe, 1);
        wait_done((TMO + 1) * PER);
        chk("failsafe_held", failsafe, 1);
        repeat (2) @(negedge clock);
        randomize_cmds();
        do_load(L);
        chk("failsafe_cleared_by_load", failsafe, 0);
        push_frame(L + 2, 0);
        wait_done(2 * FRAME_LEN);

        // Disarmed frame sends zero; arming mid-frame only affects the next one.
        repeat (2) @(negedge clock);
        armed = 1'b0;
        m_cmd = '{1046, 0, 0, 0};
        m_tlm = '{0, 0, 0, 0};
        do_load(L);
        S = L + 2;
        push_frame(S, 1);
        wait_until(S + 50);
        armed = 1'b1;
        S = S + PER;
        push_lit({16'h0000, 16'h0000, 16'h0000, 16'h82C6}, S);
        wait_done(2 * PER);

        // Asynchronous reset in the middle of a bit.
        S = S + PER;
        push_lit({16'h0000, 16'h0000, 16'h0000, 16'h82C6}, S);
        wait_until(S + 30);
        #2 reset_n = 1'b0;
        #1;
        chk("midframe_reset_tx_out", tx_out, 0);
        chk("midframe_reset_busy", busy, 0);
        chk("midframe_reset_frame_done", frame_done, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        R = cyc;
        hits = 0;
        for (int i = 1; i < PER; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || tx_out !== '0) hits++;
        end
        chk("idle_after_reset", hits, 0);
        push_frame(R + PER, 1);
        wait_done(2 * FRAME_LEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
